pb_gesture_decoder: RTL

PB_GESTURE_DECODER -- requirements
Module: pb_gesture_decoder

---
 rtl/pb_gesture_decoder.sv | 129 ++++++++++++
 1 files changed

// File: rtl/pb_gesture_decoder.sv
// Push-button gesture decoder: turns debounced press/release events into
// single-click, double-click, long-press and auto-repeat pulses.
//
// state | meaning
// IDLE  | no gesture in progress
// HELD1 | first press held, watching for release or long-press threshold
// WAIT2 | released once, waiting for a second press within the window
// HELD2 | second press of a double click held, waiting for release
// LONG  | long hold, emitting periodic repeat ticks
module pb_gesture_decoder #(
    parameter int LONG_CYCLES   = 20,
    parameter int DCLICK_CYCLES = 8,
    parameter int REPEAT_CYCLES = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic pressed_pulse,
    input  logic released_pulse,
    input  logic pressed_status,
    output logic single_pulse,
    output logic double_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic hold_status
);

    localparam int MAX_LD  = (LONG_CYCLES > DCLICK_CYCLES) ? LONG_CYCLES : DCLICK_CYCLES;
    localparam int MAX_CYC = (MAX_LD > REPEAT_CYCLES) ? MAX_LD : REPEAT_CYCLES;
    localparam int TW      = $clog2(MAX_CYC + 1);

    localparam logic [TW-1:0] LONG_LAST   = TW'(LONG_CYCLES - 1);
    localparam logic [TW-1:0] DCLICK_LAST = TW'(DCLICK_CYCLES - 1);
    localparam logic [TW-1:0] REPEAT_LAST = TW'(REPEAT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HELD1 = 3'd1,
        WAIT2 = 3'd2,
        HELD2 = 3'd3,
        LONG  = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          timer_clr;
    logic          press_ev;
    logic          single_d, double_d, long_d, repeat_d, hold_d;

    // A release arriving together with a press always wins.
    assign press_ev = pressed_pulse & ~released_pulse;

    always_comb begin
        state_d   = state_q;
        timer_clr = 1'b0;
        single_d  = 1'b0;
        double_d  = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (press_ev) state_d = HELD1;
            end
            HELD1: begin
                if (released_pulse) begin
                    state_d = WAIT2;
                end else if (!pressed_status) begin
                    state_d = IDLE;
                end else if (timer_q == LONG_LAST) begin
                    state_d = LONG;
                    long_d  = 1'b1;
                end
            end
            WAIT2: begin
                if (press_ev) begin
                    state_d  = HELD2;
                    double_d = 1'b1;
                end else if (timer_q == DCLICK_LAST) begin
                    state_d  = IDLE;
                    single_d = 1'b1;
                end
            end
            HELD2: begin
                if (released_pulse || !pressed_status) state_d = IDLE;
            end
            LONG: begin
                if (released_pulse || !pressed_status) begin
                    state_d = IDLE;
                end else if (timer_q == REPEAT_LAST) begin
                    repeat_d  = 1'b1;
                    timer_clr = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Timer saturates rather than wrapping (HELD2 has no upper bound).
    always_comb begin
        timer_d = timer_q;
        if (state_d != state_q || timer_clr) begin
            timer_d = '0;
        end else if (timer_q != {TW{1'b1}}) begin
            timer_d = timer_q + 1'b1;
        end
    end

    assign hold_d = (state_d == LONG);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            single_pulse <= 1'b0;
            double_pulse <= 1'b0;
            long_pulse   <= 1'b0;
            repeat_pulse <= 1'b0;
            hold_status  <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            single_pulse <= single_d;
            double_pulse <= double_d;
            long_pulse   <= long_d;
            repeat_pulse <= repeat_d;
            hold_status  <= hold_d;
        end
    end

endmodule
